// File: rtl/ahblite_fetch_master.sv
// rtl/ahblite_fetch_master.sv - AHB-Lite INCR read master feeding a word FIFO; option macro FETCH_BYTE_SWAP_EN
module ahblite_fetch_master #(
   parameter int FIFO_DEPTH = 4,   // read-data buffer depth in words, power of 2, >= 2
   parameter int CNT_W      = 16   // width of the word-count input
) (
   input  logic             HCLK,
   input  logic             HRESETn,
   // AHB-Lite master address/control
   output logic [31:0]      HADDR,
   output logic [1:0]       HTRANS,
   output logic [2:0]       HSIZE,
   output logic [2:0]       HBURST,
   output logic [3:0]       HPROT,
   output logic             HWRITE,
   output logic [31:0]      HWDATA,
   // AHB-Lite master response
   input  logic             HREADY,
   input  logic [31:0]      HRDATA,
   input  logic             HRESP,
   // job control
   input  logic             START,
   input  logic [31:0]      BASE_ADDR,
   input  logic [CNT_W-1:0] WORD_CNT,
   // job status
   output logic             BUSY,
   output logic             DONE,
   output logic             ERROR,
   // fetched-word stream
   output logic [31:0]      PIX_DATA,
   output logic             PIX_VALID,
   input  logic             PIX_READY
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);
   localparam logic [PTR_W+1:0] DEPTH_W = (PTR_W+2)'(FIFO_DEPTH);
   localparam logic [PTR_W:0]   PTR_ONE = (PTR_W+1)'(1);

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // bus-side state
   state_e           state_q, state_d;
   logic [31:0]      haddr_q, haddr_d;
   logic [1:0]       htrans_q, htrans_d;
   logic [CNT_W-1:0] rem_q, rem_d;       // beats not yet accepted, including the one on the bus
   logic             dvalid_q, dvalid_d; // a data phase is in progress
   logic             abort_q, abort_d;   // current data phase belongs to an errored job
   logic             done_q, done_d;
   logic             error_q, error_d;

   // read-data FIFO
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
   logic [PTR_W:0]   fifo_cnt, cnt_next;
   logic [PTR_W+1:0] committed;
   logic             fifo_full;

   // per-cycle decisions
   logic             accept;
   logic             push_req, push_ok, pop;
   logic             credit_ok;
   logic             err_first;
   logic [CNT_W-1:0] rem_after;
   logic [31:0]      next_addr;
   logic [31:0]      wdata;

   // fixed read-only control
   assign HWRITE = 1'b0;
   assign HSIZE  = 3'b010;
   assign HBURST = 3'b001;
   assign HPROT  = 4'b0011;
   assign HWDATA = 32'h0;

   assign HADDR  = haddr_q;
   assign HTRANS = htrans_q;
   assign BUSY   = (state_q != ST_IDLE);
   assign DONE   = done_q;
   assign ERROR  = error_q;

`ifdef FETCH_BYTE_SWAP_EN
   assign wdata = {HRDATA[7:0], HRDATA[15:8], HRDATA[23:16], HRDATA[31:24]};
`else
   assign wdata = HRDATA;
`endif

   // An address phase moves to data phase on any HREADY-high edge
   assign accept    = HREADY & htrans_q[1];
   // First cycle of a two-cycle ERROR response; only the first one matters
   assign err_first = dvalid_q & HRESP & ~HREADY & ~abort_q;

   assign fifo_cnt  = wr_ptr_q - rd_ptr_q;
   assign fifo_full = (fifo_cnt == DEPTH_C);
   assign PIX_VALID = (fifo_cnt != '0);
   assign PIX_DATA  = mem_q[rd_ptr_q[PTR_W-1:0]];
   assign pop       = PIX_VALID & PIX_READY;

   // Completed, error-free data phase of a live job; full-and-pop still accepts
   assign push_req  = dvalid_q & HREADY & ~HRESP & ~abort_q;
   assign push_ok   = push_req & (~fifo_full | pop);

   // Words the FIFO will hold after this edge plus the data phase that will
   // then be outstanding; a new beat is only issued if it still has a slot.
   assign cnt_next  = fifo_cnt + {{PTR_W{1'b0}}, push_ok} - {{PTR_W{1'b0}}, pop};
   assign committed = {1'b0, cnt_next} + {{(PTR_W+1){1'b0}}, accept};
   assign credit_ok = (committed < DEPTH_W);

   assign rem_after = rem_q - {{(CNT_W-1){1'b0}}, accept};
   assign next_addr = accept ? (haddr_q + 32'd4) : haddr_q;

   // Next-state and next-bus-phase decisions
   always_comb begin
      state_d  = state_q;
      haddr_d  = haddr_q;
      htrans_d = htrans_q;
      rem_d    = rem_q;
      dvalid_d = dvalid_q;
      abort_d  = abort_q;
      done_d   = 1'b0;
      error_d  = error_q;

      case (state_q)
         ST_IDLE: begin
            if (START) begin
               error_d  = 1'b0;
               haddr_d  = {BASE_ADDR[31:2], 2'b00};
               rem_d    = WORD_CNT;
               htrans_d = TR_IDLE;
               dvalid_d = 1'b0;
               abort_d  = 1'b0;
               if (WORD_CNT == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d = ST_FETCH;
               end
            end
         end

         ST_FETCH: begin
            if (err_first) begin
               // cancel the pending address phase and drop the rest of the job
               htrans_d = TR_IDLE;
               rem_d    = '0;
               error_d  = 1'b1;
               abort_d  = 1'b1;
               state_d  = ST_DRAIN;
            end else if (HREADY) begin
               dvalid_d = accept;
               haddr_d  = next_addr;
               rem_d    = rem_after;
               if (rem_after == '0) begin
                  htrans_d = TR_IDLE;
                  state_d  = ST_DRAIN;
               end else if (credit_ok) begin
                  // restart the burst after a gap or at a 1 KB boundary
                  if ((htrans_q == TR_IDLE) || (next_addr[9:0] == 10'd0)) begin
                     htrans_d = TR_NONSEQ;
                  end else begin
                     htrans_d = TR_SEQ;
                  end
               end else begin
                  htrans_d = TR_IDLE;
               end
            end
         end

         ST_DRAIN: begin
            if (err_first) begin
               error_d = 1'b1;
               abort_d = 1'b1;
            end else if (HREADY) begin
               state_d  = ST_IDLE;
               dvalid_d = 1'b0;
               abort_d  = 1'b0;
               done_d   = 1'b1;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control and bus registers
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q  <= ST_IDLE;
         haddr_q  <= 32'h0;
         htrans_q <= TR_IDLE;
         rem_q    <= '0;
         dvalid_q <= 1'b0;
         abort_q  <= 1'b0;
         done_q   <= 1'b0;
         error_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         haddr_q  <= haddr_d;
         htrans_q <= htrans_d;
         rem_q    <= rem_d;
         dvalid_q <= dvalid_d;
         abort_q  <= abort_d;
         done_q   <= done_d;
         error_q  <= error_d;
      end
   end

   // FIFO pointers: push from completed data phases, pop on the pixel handshake
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_q <= wr_ptr_q + PTR_ONE;
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

   // Storage array; contents need no reset because occupancy gates PIX_VALID
   always_ff @(posedge HCLK) begin
      if (push_ok) begin
         mem_q[wr_ptr_q[PTR_W-1:0]] <= wdata;
      end
   end

endmodule

// File: tb/tb_ahblite_fetch_master.sv
// tb/tb_ahblite_fetch_master.sv - self-checking bench for ahblite_fetch_master
module tb_ahblite_fetch_master;

   localparam int DEPTH = 4;
   localparam int CW    = 16;

   logic          HCLK;
   logic          HRESETn;
   logic [31:0]   HADDR;
   logic [1:0]    HTRANS;
   logic [2:0]    HSIZE;
   logic [2:0]    HBURST;
   logic [3:0]    HPROT;
   logic          HWRITE;
   logic [31:0]   HWDATA;
   logic          HREADY;
   logic [31:0]   HRDATA;
   logic          HRESP;
   logic          START;
   logic [31:0]   BASE_ADDR;
   logic [CW-1:0] WORD_CNT;
   logic          BUSY;
   logic          DONE;
   logic          ERROR;
   logic [31:0]   PIX_DATA;
   logic          PIX_VALID;
   logic          PIX_READY;

   ahblite_fetch_master #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST),
      .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA),
      .HREADY(HREADY), .HRDATA(HRDATA), .HRESP(HRESP),
      .START(START), .BASE_ADDR(BASE_ADDR), .WORD_CNT(WORD_CNT),
      .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
      .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID), .PIX_READY(PIX_READY)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [31:0] base;
      int          cnt;
      int          pix_pct;
      int          rdy_pct;
      int          err_beat;
      int          exp_words;
      bit          exp_err;
   } job_t;

   int checks = 0;
   int failures = 0;

   // slave / monitor state
   logic [31:0] acc_q[$];
   logic [1:0]  type_q[$];
   logic [31:0] out_q[$];
   int pix_pct, rdy_pct, err_beat, stall_beat, stall_left;
   bit pix_low;
   int done_cnt, viol, hold_cnt, active_cnt, beat_n, popped_n;
   bit dp_act, err_second, err_first, cont, rdy, rsp;
   logic [31:0] dp_addr;
   int dp_beat;
   logic [1:0]  prev_htrans;
   logic [31:0] prev_haddr;
   bit prev_hready, prev_err_first;

   function automatic logic [31:0] bus_word(input logic [31:0] a);
      return (a ^ 32'hC3A5_0F1E) + {a[7:0], a[31:24], a[15:8], a[23:16]};
   endfunction

   function automatic logic [31:0] exp_word(input logic [31:0] a);
      logic [31:0] w;
      w = bus_word(a);
`ifdef FETCH_BYTE_SWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   // AHB slave, pixel sink and protocol monitor, all working mid-cycle
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         dp_act = 0; err_second = 0; prev_htrans = 2'b00; prev_haddr = 32'h0;
         prev_hready = 1; prev_err_first = 0;
         HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; PIX_READY = 1'b0;
      end else begin
         cont = !prev_hready && prev_htrans[1] && !prev_err_first;
         if (prev_err_first && HTRANS != 2'b00) viol++;
         if (cont) begin
            hold_cnt++;
            if (HTRANS != prev_htrans || HADDR != prev_haddr) viol++;
         end else if (HTRANS[1]) begin
            if (HTRANS != (((prev_htrans == 2'b00) || (HADDR[9:0] == 10'd0)) ? 2'b10 : 2'b11)) viol++;
         end
         if (HTRANS == 2'b01) viol++;
         if (HTRANS[1]) active_cnt++;
         if (DONE) done_cnt++;

         err_first = 0;
         if (err_second) begin
            rdy = 1; rsp = 1; err_second = 0;
         end else if (dp_act && dp_beat == err_beat) begin
            rdy = 0; rsp = 1; err_second = 1; err_first = 1;
         end else if (dp_act && dp_beat == stall_beat && stall_left > 0) begin
            rdy = 0; rsp = 0; stall_left--;
         end else if (dp_act && $urandom_range(99) < rdy_pct) begin
            rdy = 0; rsp = 0;
         end else begin
            rdy = 1; rsp = 0;
         end
         HREADY = rdy;
         HRESP  = rsp;
         HRDATA = dp_act ? bus_word(dp_addr) : 32'h0;

         PIX_READY = pix_low ? 1'b0 : ($urandom_range(99) < pix_pct);
         if (PIX_VALID && PIX_READY) begin
            out_q.push_back(PIX_DATA);
            popped_n++;
         end

         if (rdy) begin
            if (HTRANS[1]) begin
               acc_q.push_back(HADDR);
               type_q.push_back(HTRANS);
               beat_n++;
               dp_act = 1; dp_addr = HADDR; dp_beat = beat_n;
            end else begin
               dp_act = 0;
            end
         end
         if (beat_n - popped_n > DEPTH) viol++;

         prev_htrans = HTRANS; prev_haddr = HADDR;
         prev_hready = rdy; prev_err_first = err_first;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge HCLK);
      #1;
   endtask

   task automatic prep(input int ppct, input int rpct, input int eb, input int sb, input int sl);
      pix_pct = ppct; rdy_pct = rpct; err_beat = eb; stall_beat = sb; stall_left = sl; pix_low = 0;
      acc_q.delete(); type_q.delete(); out_q.delete();
      done_cnt = 0; viol = 0; hold_cnt = 0; active_cnt = 0; beat_n = 0; popped_n = 0;
   endtask

   task automatic start_job(input logic [31:0] base, input int cnt);
      START = 1'b1; BASE_ADDR = base; WORD_CNT = cnt[CW-1:0];
      tick();
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      for (int i = 0; i < budget && done_cnt == 0; i++) tick();
   endtask

   task automatic drain(input int exp_words);
      pix_low = 0; pix_pct = 100;
      for (int i = 0; i < 400 && out_q.size() < exp_words; i++) tick();
      repeat (6) tick();
   endtask

   // compare everything a finished job leaves behind against the model
   task automatic check_job(input string tag, input logic [31:0] base, input int exp_beats,
                            input int exp_words, input bit exp_err);
      logic [31:0] ab;
      int bad;
      ab = {base[31:2], 2'b00};
      chk({tag, "_done"}, done_cnt, 1);
      chk({tag, "_error"}, ERROR, exp_err);
      chk({tag, "_busy"}, BUSY, 0);
      chk({tag, "_nwords"}, out_q.size(), exp_words);
      for (int i = 0; i < exp_words && i < out_q.size(); i++)
         chk($sformatf("%s_word%0d", tag, i), out_q[i], exp_word(ab + 32'(4 * i)));
      chk({tag, "_nbeats"}, acc_q.size(), exp_beats);
      bad = 0;
      for (int i = 0; i < acc_q.size(); i++)
         if (acc_q[i] !== ab + 32'(4 * i)) bad++;
      chk({tag, "_addrs"}, bad, 0);
      chk({tag, "_proto"}, viol, 0);
   endtask

   task automatic run_job(input string tag, input job_t j);
      prep(j.pix_pct, j.rdy_pct, j.err_beat, 0, 0);
      start_job(j.base, j.cnt);
      wait_done(3000);
      drain(j.exp_words);
      check_job(tag, j.base, j.exp_err ? j.err_beat : j.cnt, j.exp_words, j.exp_err);
   endtask

   job_t tbl[6];
   job_t jr;
   int   nns;

   initial begin
      HRESETn = 1'b0; START = 1'b0; BASE_ADDR = 32'h0; WORD_CNT = '0;
      HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'h0; PIX_READY = 1'b0;
      prep(100, 0, 0, 0, 0);

      tbl[0] = '{32'h1000_0107, 12, 50, 30, 0, 12, 1'b0};
      tbl[1] = '{32'h2000_0000,  8, 100, 0, 3,  2, 1'b1};
      tbl[2] = '{32'h3FF0_03F0, 20, 30, 20, 0, 20, 1'b0};
      tbl[3] = '{32'h0000_0FF8,  6, 70, 50, 5,  4, 1'b1};
      tbl[4] = '{32'h0000_0004,  1, 100, 0, 0,  1, 1'b0};
      tbl[5] = '{32'h5555_07FC,  9, 10, 60, 0,  9, 1'b0};

      repeat (3) tick();
      #1 HRESETn = 1'b1;
      tick();

      // reset values and fixed controls
      chk("rst_htrans", HTRANS, 0);
      chk("rst_haddr", HADDR, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_error", ERROR, 0);
      chk("rst_pix_valid", PIX_VALID, 0);
      chk("const_ctrl", {HWRITE, HSIZE, HBURST, HPROT}, {1'b0, 3'b010, 3'b001, 4'b0011});
      chk("const_hwdata", HWDATA, 0);

      // zero-length job: DONE next cycle, never busy, no bus activity
      prep(100, 0, 0, 0, 0);
      start_job(32'h2000_0040, 0);
      chk("zero_done_pulse", DONE, 1);
      chk("zero_busy", BUSY, 0);
      repeat (8) tick();
      chk("zero_done_once", done_cnt, 1);
      chk("zero_no_trans", active_cnt, 0);

      // straight 8-beat burst
      prep(100, 0, 0, 0, 0);
      start_job(32'h2000_0000, 8);
      wait_done(3000); drain(8);
      check_job("burst8", 32'h2000_0000, 8, 8, 1'b0);
      nns = 0;
      foreach (type_q[i]) if (type_q[i] == 2'b10) nns++;
      chk("burst8_first_nonseq", type_q.size() > 0 ? type_q[0] : 2'b00, 2'b10);
      chk("burst8_nonseq_count", nns, 1);

      // 1 KB boundary restarts the burst
      prep(100, 0, 0, 0, 0);
      start_job(32'h2000_03F8, 4);
      wait_done(3000); drain(4);
      check_job("kb", 32'h2000_03F8, 4, 4, 1'b0);
      chk("kb_types", type_q.size() == 4 ? {type_q[0], type_q[1], type_q[2], type_q[3]} : 8'h0,
          {2'b10, 2'b11, 2'b10, 2'b11});

      // table of jobs, including error jobs followed by clean ones
      for (int t = 0; t < 6; t++) run_job($sformatf("tbl%0d", t), tbl[t]);

      // back-pressure: only DEPTH beats issued, START ignored while busy
      prep(100, 0, 0, 0, 0);
      pix_low = 1;
      start_job(32'h2000_1000, 16);
      repeat (30) tick();
      chk("bp_beats", acc_q.size(), DEPTH);
      chk("bp_idle", HTRANS, 0);
      chk("bp_busy", BUSY, 1);
      start_job(32'h3000_0000, 3);
      pix_low = 0;
      wait_done(3000); drain(16);
      check_job("bp", 32'h2000_1000, 16, 16, 1'b0);
      chk("bp_resume_nonseq", type_q.size() > DEPTH ? type_q[DEPTH] : 2'b00, 2'b10);

      // three wait states in the middle of a burst
      prep(100, 0, 0, 3, 3);
      start_job(32'h2000_2000, 8);
      wait_done(3000); drain(8);
      check_job("stall", 32'h2000_2000, 8, 8, 1'b0);
      chk("stall_holds", hold_cnt, 3);

      // randomised jobs against the model
      for (int r = 0; r < 6; r++) begin
         jr.base = 32'h4000_0000 | (32'($urandom_range(0, 4095)) << 2);
         jr.cnt = $urandom_range(1, 24);
         jr.pix_pct = $urandom_range(20, 100);
         jr.rdy_pct = $urandom_range(0, 50);
         jr.err_beat = ($urandom_range(0, 2) == 0) ? $urandom_range(1, jr.cnt) : 0;
         jr.exp_err = (jr.err_beat != 0);
         jr.exp_words = jr.exp_err ? jr.err_beat - 1 : jr.cnt;
         run_job($sformatf("rnd%0d", r), jr);
      end

      // reset in the middle of a job
      prep(100, 0, 0, 0, 0);
      start_job(32'h2000_0000, 8);
      for (int i = 0; i < 200 && acc_q.size() < 5; i++) tick();
      chk("mid_reached_beat5", acc_q.size() >= 5, 1);
      #1 HRESETn = 1'b0;
      #1;
      chk("mid_rst_htrans", HTRANS, 0);
      chk("mid_rst_haddr", HADDR, 0);
      chk("mid_rst_busy", BUSY, 0);
      chk("mid_rst_done", DONE, 0);
      chk("mid_rst_pix_valid", PIX_VALID, 0);
      tick();
      #1 HRESETn = 1'b1;
      done_cnt = 0;
      repeat (20) tick();
      chk("mid_no_done", done_cnt, 0);
      chk("mid_idle_busy", BUSY, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ahblite_fetch_master.md
AHBLITE_FETCH_MASTER -- requirements
Module: ahblite_fetch_master

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, read-data buffer depth in words (power of 2, ≥2).
REQ-002 SHALL have parameter CNT_W, default 16, width of the word-count input.
REQ-003 SHALL have port HCLK, input, 1: the single clock; all logic rising-edge.
REQ-004 SHALL have port HRESETn, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have ports HADDR out 32, HTRANS out 2, HSIZE out 3, HBURST out 3, HPROT out 4, HWRITE out 1, HWDATA out 32: AHB-Lite master address/control.
REQ-006 SHALL have ports HREADY in 1, HRDATA in 32, HRESP in 1: AHB-Lite master response.
REQ-007 SHALL have ports START in 1 (one-cycle request), BASE_ADDR in 32, WORD_CNT in CNT_W: job control.
REQ-008 SHALL have ports BUSY out 1, DONE out 1 (one-cycle pulse), ERROR out 1 (sticky): job status.
REQ-009 SHALL have ports PIX_DATA out 32, PIX_VALID out 1, PIX_READY in 1: fetched-word stream to the HDMI path.

Function
REQ-010 SHALL drive HWRITE=0, HSIZE=3'b010, HBURST=3'b001 (INCR), HPROT=4'b0011, HWDATA=0 constantly.
REQ-011 SHALL implement FSM IDLE→FETCH→DRAIN→IDLE; START in IDLE latches {BASE_ADDR[31:2],2'b00} and WORD_CNT, asserts BUSY next cycle.
REQ-012 SHALL ignore START while BUSY=1.
REQ-013 SHALL, when WORD_CNT=0 at START, issue no transfer and pulse DONE one cycle later, BUSY staying 0.
REQ-014 SHALL in FETCH issue an address phase only when credits > 0 (credits = free FIFO slots − outstanding data phases) and words remain; otherwise drive HTRANS=IDLE.
REQ-015 SHALL drive HTRANS=NONSEQ for the first beat, after any IDLE cycle, and when HADDR[9:0]=0 (1 KB boundary); SEQ otherwise.
REQ-016 SHALL hold HADDR/HTRANS stable while HREADY=0; advance HADDR by 4 only on an accepted beat (HREADY=1, HTRANS[1]=1).
REQ-017 SHALL pipeline: data phase of beat N overlaps address phase of beat N+1; HRDATA written to FIFO when HREADY=1 in a valid data phase.
REQ-018 SHALL enter DRAIN after the last address phase accepted; exit to IDLE when last data phase completes, pulsing DONE and clearing BUSY the same edge.
REQ-019 SHALL, on HRESP=1 with HREADY=0 (first error cycle), drive HTRANS=IDLE next cycle, discard remaining beats, set ERROR, then pulse DONE and return to IDLE; errored beat not written to FIFO.
REQ-020 SHALL present FIFO head as PIX_DATA/PIX_VALID; pop on PIX_VALID&PIX_READY; simultaneous push and pop at full or empty SHALL both succeed.
REQ-021 SHALL not flush FIFO at DONE; words drain independently of BUSY.
REQ-022 SHALL clear ERROR only on next accepted START.

Reset
REQ-023 SHALL on HRESETn=0 asynchronously: FSM=IDLE, HTRANS=IDLE, HADDR=0, BUSY=0, DONE=0, ERROR=0, PIX_VALID=0, FIFO empty, counters 0.
REQ-024 SHALL, on reset mid-job, abandon the job with no DONE pulse after release.

Configuration
REQ-025 SHALL, with macro FETCH_BYTE_SWAP_EN defined, byte-reverse each HRDATA word before FIFO write ({[7:0],[15:8],[23:16],[31:24]}).
REQ-026 SHALL, without FETCH_BYTE_SWAP_EN, store HRDATA unmodified.

Verification
REQ-027 START, BASE_ADDR=0x2000_0000, WORD_CNT=8, HREADY=1, PIX_READY=1 -> 8 beats NONSEQ+7 SEQ, HADDR 0x2000_0000..0x2000_001C, 8 words out in order, one DONE.
REQ-028 BASE_ADDR=0x2000_03F8, WORD_CNT=4 -> HTRANS NONSEQ,SEQ,NONSEQ(at 0x2000_0400),SEQ.
REQ-029 WORD_CNT=16, PIX_READY=0 -> exactly FIFO_DEPTH beats issued then HTRANS=IDLE; PIX_READY=1 resumes with NONSEQ; all 16 words delivered.
REQ-030 HRESP error on beat 3 of 8 -> HTRANS=IDLE next cycle, ERROR=1, DONE once, only beats 1-2 in FIFO.
REQ-031 HREADY=0 for 3 cycles mid-burst -> HADDR/HTRANS held; WORD_CNT=0 -> DONE next cycle, no HTRANS activity.
REQ-032 HRESETn low during beat 5 of 8 -> all outputs at reset values immediately; no DONE after release.
